// File: rtl/poly_eval_engine.sv
// Horner-method polynomial evaluator fed by FWFT instruction/data FIFOs, producing a
// result word and a status word per instruction, with wrap or saturate overflow handling.
module poly_eval_engine #(
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned DEGREE_WIDTH = 4,
    parameter int unsigned MAX_DEGREE   = 15,
    parameter int unsigned SATURATE     = 0
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [DEGREE_WIDTH+3:0]   instruction,
    input  logic                      empty_instruction,
    output logic                      read_enable_instruction,
    input  logic [DATA_WIDTH-1:0]     data,
    input  logic                      empty_data,
    output logic                      read_enable_data,
    output logic [DATA_WIDTH-1:0]     result,
    input  logic                      full_result,
    output logic                      write_enable_result,
    output logic [3:0]                status,
    input  logic                      full_status,
    output logic                      write_enable_status,
    output logic                      busy
);
    localparam int unsigned DW = DATA_WIDTH;
    localparam int unsigned WW = 2 * DATA_WIDTH + 1;
    localparam int unsigned CW = DEGREE_WIDTH + 1;
    localparam logic [DEGREE_WIDTH-1:0] MAX_DEG = DEGREE_WIDTH'(MAX_DEGREE);

    typedef enum logic [1:0] {IDLE, LOAD_X, ACCUM, WRITE} state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   acc_q, acc_d;
    logic [DW-1:0]   x_q, x_d;
    logic [DW-1:0]   result_q, result_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ovf_q, ovf_d;
    logic            eval_q, eval_d;
    logic [3:0]      err_q, err_d;
    logic [3:0]      status_q, status_d;

    logic [3:0]              opcode;
    logic [DEGREE_WIDTH-1:0] degree;
    logic [WW-1:0]           acc_w, x_w, d_w, sum_w;
    logic [WW-DW:0]          upper;
    logic                    step_ovf;
    logic [DW-1:0]           sat_val, step_val;

    assign opcode = instruction[DEGREE_WIDTH+3 -: 4];
    assign degree = instruction[DEGREE_WIDTH-1:0];
    assign busy   = (state_q != IDLE);
    assign result = result_d;
    assign status = status_d;

    // Sign-extended operands make the modular WW-bit product/sum exact.
    always_comb begin
        acc_w    = {{(DW+1){acc_q[DW-1]}}, acc_q};
        x_w      = {{(DW+1){x_q[DW-1]}}, x_q};
        d_w      = {{(DW+1){data[DW-1]}}, data};
        sum_w    = acc_w * x_w + d_w;
        upper    = sum_w[WW-1:DW-1];
        step_ovf = (|upper) && !(&upper);
        sat_val  = sum_w[WW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        step_val = (SATURATE != 0 && step_ovf) ? sat_val : sum_w[DW-1:0];
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        x_d      = x_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        eval_d   = eval_q;
        err_d    = err_q;
        result_d = result_q;
        status_d = status_q;
        read_enable_instruction = 1'b0;
        read_enable_data        = 1'b0;
        write_enable_result     = 1'b0;
        write_enable_status     = 1'b0;
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    if (!empty_instruction) begin
                        read_enable_instruction = 1'b1;
                        count_d = {1'b0, degree};
                        eval_d  = 1'b0;
                        state_d = WRITE;
                        if (opcode == 4'h0) begin
                            if (degree > MAX_DEG) begin
                                err_d = 4'b1001;
                            end else begin
                                eval_d  = 1'b1;
                                state_d = LOAD_X;
                            end
                        end else if (opcode == 4'h1) begin
                            err_d = 4'b0001;
                        end else begin
                            err_d = 4'b0101;
                        end
                    end
                end
                LOAD_X: begin
                    if (!empty_data) begin
                        read_enable_data = 1'b1;
                        x_d     = data;
                        acc_d   = '0;
                        ovf_d   = 1'b0;
                        count_d = count_q + 1'b1;
                        state_d = ACCUM;
                    end
                end
                ACCUM: begin
                    if (!empty_data) begin
                        read_enable_data = 1'b1;
                        acc_d   = step_val;
                        ovf_d   = ovf_q | step_ovf;
                        count_d = count_q - 1'b1;
                        if (count_q == CW'(1)) state_d = WRITE;
                    end
                end
                WRITE: begin
                    if (!full_status && (!eval_q || !full_result)) begin
                        write_enable_status = 1'b1;
                        write_enable_result = eval_q;
                        if (eval_q) begin
                            result_d = acc_q;
                            status_d = {2'b00, ovf_q, 1'b1};
                        end else begin
                            status_d = err_q;
                        end
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            x_q      <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            eval_q   <= 1'b0;
            err_q    <= '0;
            result_q <= '0;
            status_q <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            x_q      <= x_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            eval_q   <= eval_d;
            err_q    <= err_d;
            result_q <= result_d;
            status_q <= status_d;
        end
    end
endmodule

// File: tb/tb_poly_eval_engine.sv
// Bench for poly_eval_engine: wrap and saturate instances share modelled FWFT FIFOs and
// are checked against an arithmetic Horner reference kept here.
module tb_poly_eval_engine;
    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  instruction;
    logic        empty_instruction;
    logic [15:0] data;
    logic        empty_data;
    logic        full_result;
    logic        full_status;

    logic        w_re_i, w_re_d, w_we_r, w_we_s, w_busy;
    logic [15:0] w_result;
    logic [3:0]  w_status;
    logic        s_re_i, s_re_d, s_we_r, s_we_s, s_busy;
    logic [15:0] s_result;
    logic [3:0]  s_status;

    always #5 clock = ~clock;

    poly_eval_engine #(.DATA_WIDTH(16), .DEGREE_WIDTH(4), .MAX_DEGREE(7), .SATURATE(0)) u_wrap (
        .clock(clock), .reset(reset),
        .instruction(instruction), .empty_instruction(empty_instruction),
        .read_enable_instruction(w_re_i),
        .data(data), .empty_data(empty_data), .read_enable_data(w_re_d),
        .result(w_result), .full_result(full_result), .write_enable_result(w_we_r),
        .status(w_status), .full_status(full_status), .write_enable_status(w_we_s),
        .busy(w_busy)
    );

    poly_eval_engine #(.DATA_WIDTH(16), .DEGREE_WIDTH(4), .MAX_DEGREE(7), .SATURATE(1)) u_sat (
        .clock(clock), .reset(reset),
        .instruction(instruction), .empty_instruction(empty_instruction),
        .read_enable_instruction(s_re_i),
        .data(data), .empty_data(empty_data), .read_enable_data(s_re_d),
        .result(s_result), .full_result(full_result), .write_enable_result(s_we_r),
        .status(s_status), .full_status(full_status), .write_enable_status(s_we_s),
        .busy(s_busy)
    );

    typedef struct {
        bit          has_res;
        logic [15:0] rw;
        logic [15:0] rs;
        logic [3:0]  sw;
        logic [3:0]  ss;
        int          lat;
    } exp_t;

    int total = 0;
    int bad   = 0;
    int cycle = 0;
    int pop_cycle = 0;
    int dpops = 0;
    int dpushed = 0;
    bit stall_en = 0, bp_en = 0, hold_data = 0, hold_res = 0, lat_en = 1;
    logic [7:0]  iq[$];
    logic [15:0] dq[$];
    int          cq[$];
    exp_t        exp_q[$];
    logic [15:0] last_rw = '0;

    task automatic check(input string tag, input longint obs, input longint expv);
        total++;
        if (obs != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic drive();
        instruction       = (iq.size() != 0) ? iq[0] : 8'h00;
        empty_instruction = (iq.size() == 0);
        data              = (dq.size() != 0) ? dq[0] : 16'h0000;
        empty_data        = (dq.size() == 0) || hold_data || (stall_en && $urandom_range(0, 3) == 0);
        full_result       = hold_res || (bp_en && $urandom_range(0, 2) == 0);
        full_status       = bp_en && $urandom_range(0, 3) == 0;
    endtask

    // Reference: enqueue the instruction and its data words, and predict both outputs.
    task automatic add_op(input int op, input int n, input int x);
        exp_t e;
        logic signed [15:0] t;
        longint xs, cs, ew, es, aw, acs;
        bit ow, os;
        int c;
        iq.push_back({op[3:0], n[3:0]});
        e.rw = '0; e.rs = '0;
        if (op == 0 && n <= 7) begin
            dq.push_back(x[15:0]); dpushed++;
            t = x[15:0]; xs = t;
            aw = 0; acs = 0; ow = 0; os = 0;
            for (int i = 0; i <= n; i++) begin
                c = cq.pop_front();
                dq.push_back(c[15:0]); dpushed++;
                t = c[15:0]; cs = t;
                ew = aw * xs + cs;
                if (ew > 32767 || ew < -32768) ow = 1;
                t = ew[15:0]; aw = t;
                es = acs * xs + cs;
                if (es > 32767 || es < -32768) os = 1;
                acs = (es > 32767) ? 32767 : (es < -32768) ? -32768 : es;
            end
            e.has_res = 1;
            e.rw = aw[15:0];
            e.rs = acs[15:0];
            e.sw = {2'b00, ow, 1'b1};
            e.ss = {2'b00, os, 1'b1};
            e.lat = n + 3;
        end else begin
            e.has_res = 0;
            e.sw = (op == 1) ? 4'b0001 : (op == 0) ? 4'b1001 : 4'b0101;
            e.ss = e.sw;
            e.lat = 1;
        end
        exp_q.push_back(e);
    endtask

    task automatic step();
        exp_t e;
        bit rei, red;
        @(negedge clock);
        check("one_read_w", longint'(w_re_i && w_re_d), 0);
        if (w_re_i) check("re_i_empty", empty_instruction, 0);
        if (w_re_d) check("re_d_empty", empty_data, 0);
        if (s_re_d) check("s_re_d_empty", empty_data, 0);
        if (w_we_s || w_we_r || s_we_s || s_we_r) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                check("w_we_status", w_we_s, 1);
                check("w_we_result", w_we_r, e.has_res);
                check("w_status", w_status, e.sw);
                check("s_we_status", s_we_s, 1);
                check("s_we_result", s_we_r, e.has_res);
                check("s_status", s_status, e.ss);
                check("status_full", full_status, 0);
                if (e.has_res) begin
                    check("w_result", w_result, e.rw);
                    check("s_result", s_result, e.rs);
                    check("result_full", full_result, 0);
                    last_rw = e.rw;
                end
                if (lat_en) check("latency", cycle - pop_cycle, e.lat);
            end
        end
        if (w_re_i) pop_cycle = cycle;
        rei = w_re_i;
        red = w_re_d;
        @(posedge clock);
        #1;
        cycle++;
        if (rei && iq.size() != 0) void'(iq.pop_front());
        if (red && dq.size() != 0) begin
            void'(dq.pop_front());
            dpops++;
        end
        drive();
    endtask

    task automatic run_done(input int budget);
        int k = 0;
        while ((exp_q.size() != 0 || iq.size() != 0) && k < budget) begin
            step();
            k++;
        end
        if (k >= budget) check("timeout", exp_q.size(), 0);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_result"}, w_result, 0);
        check({tag, "_status"}, w_status, 0);
        check({tag, "_busy"}, longint'(w_busy || s_busy), 0);
        check({tag, "_enables"}, longint'({w_re_i, w_re_d, w_we_r, w_we_s, s_we_r, s_we_s}), 0);
    endtask

    initial begin
        int k;
        int base;
        int r, op, n, x;
        reset = 1'b1;
        drive();
        repeat (3) step();
        check_cleared("reset");
        reset = 1'b0;

        // 3x^2 + x + 5 at x = 2
        dpops = 0;
        cq = '{3, 1, 5};
        add_op(0, 2, 2);
        drive();
        run_done(100);
        check("pops_n2", dpops, 4);
        check("idle_after", w_busy, 0);

        cq = '{1, 0, 0};
        add_op(0, 2, 300);
        cq = '{2, 4};
        add_op(0, 1, -3);
        cq = '{9};
        add_op(0, 0, 7);
        add_op(5, 3, 0);
        cq = '{1, 1};
        add_op(0, 1, 10);
        add_op(1, 0, 0);
        add_op(0, 15, 0);
        cq = '{-1, 32767};
        add_op(0, 1, 1);
        drive();
        run_done(300);
        check("pops_balance", dpops, dpushed);

        // Result FIFO held full through the write state
        lat_en = 0;
        hold_res = 1;
        cq = '{5, 6};
        add_op(0, 1, 3);
        drive();
        for (int i = 0; i < 12; i++) begin
            step();
            check("bp_no_we", longint'(w_we_r || s_we_r), 0);
            check("bp_result", w_result, last_rw);
        end
        hold_res = 0;
        drive();
        run_done(50);

        // Data FIFO held empty mid-accumulation
        base = dpops;
        cq = '{2, -7, 11, 4};
        add_op(0, 3, -5);
        drive();
        k = 0;
        while (dpops < base + 2 && k < 50) begin
            step();
            k++;
        end
        check("reach_accum", dpops, base + 2);
        hold_data = 1;
        drive();
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_no_pop", w_re_d, 0);
            check("stall_busy", w_busy, 1);
        end
        hold_data = 0;
        drive();
        run_done(50);
        check("pops_balance2", dpops, dpushed);

        // Reset in the middle of accumulation
        base = dpops;
        cq = '{1, 2, 3, 4, 5, 6};
        add_op(0, 5, 2);
        drive();
        k = 0;
        while (dpops < base + 3 && k < 50) begin
            step();
            k++;
        end
        check("reach_accum2", dpops, base + 3);
        reset = 1'b1;
        iq.delete();
        dq.delete();
        exp_q.delete();
        drive();
        step();
        reset = 1'b0;
        drive();
        check_cleared("mid_reset");
        dpops = 0;
        dpushed = 0;
        cq = '{4, -2, 1};
        add_op(0, 2, -3);
        drive();
        run_done(100);
        check("pops_after_reset", dpops, 4);

        // Randomised traffic with stalls and backpressure
        stall_en = 1;
        bp_en = 1;
        for (int b = 0; b < 4; b++) begin
            for (int j = 0; j < 10; j++) begin
                r = $urandom_range(0, 9);
                op = 0;
                n = $urandom_range(0, 7);
                if (r == 7) op = 1;
                if (r == 8) op = $urandom_range(2, 15);
                if (r == 9) n = $urandom_range(8, 15);
                if ($urandom_range(0, 1) == 0) x = $urandom_range(0, 8) - 4;
                else x = $urandom_range(0, 65535);
                if (op == 0 && n <= 7)
                    for (int i = 0; i <= n; i++) cq.push_back($urandom_range(0, 65535));
                add_op(op, n, x);
            end
            drive();
            run_done(3000);
        end
        check("pops_balance3", dpops, dpushed);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
